// File: rtl/deferred_step_batcher_if.sv
// Batched nstep request channel between the step batcher and the host DPI bridge.
interface deferred_step_batcher_if #(
  parameter int CORE_W    = 1,
  parameter int ACC_WIDTH = 16
);
  logic                 nstep_valid;
  logic                 nstep_ready;
  logic [CORE_W-1:0]    nstep_core;
  logic [ACC_WIDTH-1:0] nstep_count;

  modport master (output nstep_valid, nstep_core, nstep_count, input nstep_ready);
  modport slave  (input nstep_valid, nstep_core, nstep_count, output nstep_ready);
endinterface

// File: rtl/deferred_step_batcher.sv
// Accumulates per-core step counts into batched nstep requests, latches the first
// nonzero host result, drains pending steps and then reports completion.
module deferred_step_batcher #(
  parameter int NUM_CORES  = 2,
  parameter int STEP_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int THRESHOLD  = 64,
  parameter int TIMEOUT    = 256,
  localparam int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int IDLE_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CORES*STEP_WIDTH-1:0] step,
  deferred_step_batcher_if.master         nstep,
  input  logic                            result_valid,
  input  logic [7:0]                      result_in,
  output logic [7:0]                      simv_result,
  output logic                            drained,
  output logic                            overflow
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                                state_reg;
  logic                                  nstep_valid_reg;
  logic [CORE_W-1:0]                     nstep_core_reg;
  logic [ACC_WIDTH-1:0]                  nstep_count_reg;
  logic [CORE_W-1:0]                     ptr_reg;
  logic [7:0]                            simv_result_reg;
  logic                                  overflow_reg;

  logic [NUM_CORES-1:0][ACC_WIDTH-1:0]   acc_all;
  logic [NUM_CORES-1:0]                  eligible;
  logic [NUM_CORES-1:0]                  sat;
  logic [NUM_CORES-1:0]                  empty_next;
  logic [NUM_CORES-1:0]                  grant_onehot;
  logic [CORE_W-1:0]                     grant_idx;
  logic                                  grant_any;
  logic                                  slot_free;
  logic                                  valid_next;

  assign slot_free  = !nstep_valid_reg || nstep.nstep_ready;
  assign valid_next = slot_free ? grant_any : nstep_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      logic [ACC_WIDTH-1:0]  acc_reg, acc_next, base;
      logic [IDLE_W-1:0]     idle_reg, idle_next;
      logic [STEP_WIDTH-1:0] step_c;
      logic [ACC_WIDTH:0]    sum;
      logic                  timeout_hit;

      // Steps are only counted while running; after the result latch they are dropped.
      assign step_c      = (state_reg == RUN) ? step[gi*STEP_WIDTH +: STEP_WIDTH] : '0;
      assign base        = grant_onehot[gi] ? '0 : acc_reg;
      assign sum         = {1'b0, base} + {{(ACC_WIDTH+1-STEP_WIDTH){1'b0}}, step_c};
      assign sat[gi]     = sum[ACC_WIDTH];
      assign acc_next    = sat[gi] ? '1 : sum[ACC_WIDTH-1:0];
      assign timeout_hit = (TIMEOUT != 0) && (idle_reg == IDLE_W'(TIMEOUT));
      assign eligible[gi] = (acc_reg != '0) &&
                            ((acc_reg >= ACC_WIDTH'(THRESHOLD)) || timeout_hit || (state_reg == DRAIN));
      assign empty_next[gi] = (acc_next == '0);
      assign acc_all[gi]    = acc_reg;

      always_comb begin
        idle_next = idle_reg;
        if (step_c != '0 || grant_onehot[gi])
          idle_next = '0;
        else if (acc_reg != '0 && idle_reg != IDLE_W'(TIMEOUT))
          idle_next = idle_reg + 1'b1;
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          acc_reg  <= '0;
          idle_reg <= '0;
        end else begin
          acc_reg  <= acc_next;
          idle_reg <= idle_next;
        end
      end
    end
  endgenerate

  // Round-robin: first eligible core at or after the pointer.
  always_comb begin
    int c;
    c            = 0;
    grant_any    = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      c = (int'(ptr_reg) + k) % NUM_CORES;
      if (!grant_any && eligible[c]) begin
        grant_any = 1'b1;
        grant_idx = CORE_W'(c);
      end
    end
    if (slot_free && grant_any)
      grant_onehot[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= RUN;
      nstep_valid_reg <= 1'b0;
      nstep_core_reg  <= '0;
      nstep_count_reg <= '0;
      ptr_reg         <= '0;
      simv_result_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      overflow_reg <= overflow_reg | (|sat);
      if (slot_free) begin
        nstep_valid_reg <= grant_any;
        if (grant_any) begin
          nstep_core_reg  <= grant_idx;
          nstep_count_reg <= acc_all[grant_idx];
          ptr_reg         <= (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + 1'b1;
        end
      end
      case (state_reg)
        RUN: begin
          if (result_valid && result_in != 8'd0) begin
            simv_result_reg <= result_in;
            state_reg       <= DRAIN;
          end
        end
        // Look at next-cycle values so drained rises right after the final handshake.
        DRAIN: begin
          if (&empty_next && !valid_next)
            state_reg <= DONE;
        end
        default: state_reg <= DONE;
      endcase
    end
  end

  assign nstep.nstep_valid = nstep_valid_reg;
  assign nstep.nstep_core  = nstep_core_reg;
  assign nstep.nstep_count = nstep_count_reg;
  assign simv_result       = simv_result_reg;
  assign overflow          = overflow_reg;
  assign drained           = (state_reg == DONE);

endmodule
